// File: rtl/alu_unit_pkg.sv
// Shared constants and types for the ALU unit slice.
// Holds the default ROB tag width and result buffer depth, the RV32I
// opcodes and funct3 encodings the ALU decodes, and the buffered result
// record.
package alu_unit_pkg;

    localparam int unsigned ROB_BIT_DEFAULT    = 4;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_f3_e;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] next_pc;
    } alu_out_t;

endpackage

// File: rtl/alu_unit_core.sv
// alu_core: purely combinational RV32I integer datapath.
// Ports:
//   i_vi, i_vj      operand 1 / operand 2 (vj already immediate for OP-IMM)
//   i_op            funct3
//   i_op_type       opcode
//   i_op_addition   inst[30] (sub / sra select)
//   i_pc, i_imm     instruction address, sign-extended immediate
//   o_result        value written back (branch: 1 = taken)
//   o_next_pc       resolved successor PC
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [31:0] i_vi,
    input  logic [31:0] i_vj,
    input  logic [2:0]  i_op,
    input  logic [6:0]  i_op_type,
    input  logic        i_op_addition,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    output logic [31:0] o_result,
    output logic [31:0] o_next_pc
);

    logic [4:0]  w_shamt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus_imm;
    logic        w_lt;
    logic        w_ltu;
    logic        w_taken;

    assign w_shamt       = i_vj[4:0];
    assign w_pc_plus4    = i_pc + 32'd4;
    assign w_pc_plus_imm = i_pc + i_imm;
    assign w_lt          = $signed(i_vi) < $signed(i_vj);
    assign w_ltu         = i_vi < i_vj;

    always_comb begin
        w_taken = 1'b0;
        case (i_op)
            BR_EQ:   w_taken = (i_vi == i_vj);
            BR_NE:   w_taken = (i_vi != i_vj);
            BR_LT:   w_taken = w_lt;
            BR_GE:   w_taken = !w_lt;
            BR_LTU:  w_taken = w_ltu;
            BR_GEU:  w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        o_result  = '0;
        o_next_pc = w_pc_plus4;
        case (i_op_type)
            OPC_OP, OPC_OP_IMM: begin
                case (i_op)
                    // inst[30] only selects subtract for register-register ops
                    F3_ADD:  o_result = (i_op_type == OPC_OP && i_op_addition)
                                        ? i_vi - i_vj : i_vi + i_vj;
                    F3_SLL:  o_result = i_vi << w_shamt;
                    F3_SLT:  o_result = {31'd0, w_lt};
                    F3_SLTU: o_result = {31'd0, w_ltu};
                    F3_XOR:  o_result = i_vi ^ i_vj;
                    F3_SR:   o_result = i_op_addition
                                        ? $unsigned($signed(i_vi) >>> w_shamt)
                                        : i_vi >> w_shamt;
                    F3_OR:   o_result = i_vi | i_vj;
                    F3_AND:  o_result = i_vi & i_vj;
                    default: o_result = '0;
                endcase
            end
            OPC_BRANCH: begin
                o_result  = {31'd0, w_taken};
                o_next_pc = w_taken ? w_pc_plus_imm : w_pc_plus4;
            end
            OPC_JAL: begin
                o_result  = w_pc_plus4;
                o_next_pc = w_pc_plus_imm;
            end
            OPC_JALR: begin
                o_result  = w_pc_plus4;
                o_next_pc = (i_vi + i_imm) & ~32'd1;
            end
            OPC_LUI:   o_result = i_imm;
            OPC_AUIPC: o_result = w_pc_plus_imm;
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: dispatch-side wrapper around alu_core with an in-order result
// buffer feeding the CDB.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low = hold everything)
//   rob_clear_up                    mispredict flush
//   start_alu, vi, vj, op, op_type, op_addition, alu_rob_entry,
//   pc_in, imm_in                   dispatch from the RS
//   cdb_grant                       CDB accepts the head result
//   alu_full                        buffer full, RS must not dispatch
//   alu_ready, finished_alu_rob_entry, alu_result, next_pc   head result
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int unsigned ROB_BIT    = ROB_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
)(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               start_alu,
    input  logic [31:0]        vi,
    input  logic [31:0]        vj,
    input  logic [2:0]         op,
    input  logic [6:0]         op_type,
    input  logic               op_addition,
    input  logic [ROB_BIT-1:0] alu_rob_entry,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        imm_in,
    input  logic               cdb_grant,
    output logic               alu_full,
    output logic               alu_ready,
    output logic [ROB_BIT-1:0] finished_alu_rob_entry,
    output logic [31:0]        alu_result,
    output logic [31:0]        next_pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    alu_out_t           r_data [FIFO_DEPTH];
    logic [ROB_BIT-1:0] r_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [31:0] w_result;
    logic [31:0] w_next_pc;
    logic        w_push;
    logic        w_pop;

    alu_core u_core (
        .i_vi          (vi),
        .i_vj          (vj),
        .i_op          (op),
        .i_op_type     (op_type),
        .i_op_addition (op_addition),
        .i_pc          (pc_in),
        .i_imm         (imm_in),
        .o_result      (w_result),
        .o_next_pc     (w_next_pc)
    );

    assign alu_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign alu_ready = (r_count != '0);
    // A flush wins over any same-cycle dispatch or pop.
    assign w_push    = rdy_in && start_alu && !alu_full && !rob_clear_up;
    assign w_pop     = rdy_in && alu_ready && cdb_grant && !rob_clear_up;

    // Empty buffer presents zeros so outputs read 0 right after reset/flush.
    assign finished_alu_rob_entry = alu_ready ? r_tag[r_rd_ptr] : '0;
    assign alu_result             = alu_ready ? r_data[r_rd_ptr].result : '0;
    assign next_pc                = alu_ready ? r_data[r_rd_ptr].next_pc : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push && !rst_in) begin
            r_data[r_wr_ptr] <= '{result: w_result, next_pc: w_next_pc};
            r_tag[r_wr_ptr]  <= alu_rob_entry;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_alu_unit;

    localparam int unsigned RB    = 4;
    localparam int unsigned DEPTH = 2;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, rob_clear_up, start_alu;
    logic [31:0]   vi, vj, pc_in, imm_in;
    logic [2:0]    op;
    logic [6:0]    op_type;
    logic          op_addition, cdb_grant;
    logic [RB-1:0] alu_rob_entry;
    logic          alu_full, alu_ready;
    logic [RB-1:0] finished_alu_rob_entry;
    logic [31:0]   alu_result, next_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [RB-1:0] tag;
        logic [31:0]   res;
        logic [31:0]   npc;
    } exp_t;
    exp_t q[$];

    alu_unit #(.ROB_BIT(RB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .rob_clear_up           (rob_clear_up),
        .start_alu              (start_alu),
        .vi                     (vi),
        .vj                     (vj),
        .op                     (op),
        .op_type                (op_type),
        .op_addition            (op_addition),
        .alu_rob_entry          (alu_rob_entry),
        .pc_in                  (pc_in),
        .imm_in                 (imm_in),
        .cdb_grant              (cdb_grant),
        .alu_full               (alu_full),
        .alu_ready              (alu_ready),
        .finished_alu_rob_entry (finished_alu_rob_entry),
        .alu_result             (alu_result),
        .next_pc                (next_pc)
    );

    always #5 clk_in = ~clk_in;

    // RV32I semantics written from the instruction definitions.
    function automatic void ref_compute(
        input  logic [6:0]  opc,
        input  logic [2:0]  f3,
        input  logic        add,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [31:0] pc,
        input  logic [31:0] imm,
        output logic [31:0] res,
        output logic [31:0] npc);
        logic [4:0] sh;
        logic       lt_s, lt_u, tk;
        sh   = b[4:0];
        lt_u = a < b;
        lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        res  = 32'd0;
        npc  = pc + 32'd4;
        tk   = 1'b0;
        if (opc == 7'h33 || opc == 7'h13) begin
            case (f3)
                3'd0: res = (opc == 7'h33 && add) ? a + (~b + 32'd1) : a + b;
                3'd1: res = a << sh;
                3'd2: res = {31'd0, lt_s};
                3'd3: res = {31'd0, lt_u};
                3'd4: res = a ^ b;
                3'd5: res = (a >> sh) | ((add && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (opc == 7'h63) begin
            case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = lt_s;
                3'd5: tk = !lt_s;
                3'd6: tk = lt_u;
                3'd7: tk = !lt_u;
                default: tk = 1'b0;
            endcase
            res = {31'd0, tk};
            npc = tk ? pc + imm : pc + 32'd4;
        end else if (opc == 7'h6F) begin
            res = pc + 32'd4;
            npc = pc + imm;
        end else if (opc == 7'h67) begin
            res = pc + 32'd4;
            npc = (a + imm) & 32'hFFFF_FFFE;
        end else if (opc == 7'h37) begin
            res = imm;
        end else if (opc == 7'h17) begin
            res = pc + imm;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model with the inputs the DUT is about to sample.
    task automatic model_step();
        exp_t e;
        bit   was_full, was_ready;
        if (rst_in) begin
            q.delete();
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                q.delete();
            end else begin
                was_full  = (q.size() == DEPTH);
                was_ready = (q.size() != 0);
                if (was_ready && cdb_grant) void'(q.pop_front());
                if (start_alu && !was_full) begin
                    ref_compute(op_type, op, op_addition, vi, vj, pc_in, imm_in, e.res, e.npc);
                    e.tag = alu_rob_entry;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("ready", {31'd0, alu_ready}, {31'd0, q.size() != 0});
        check("full",  {31'd0, alu_full},  {31'd0, q.size() == DEPTH});
        if (q.size() != 0) begin
            check("tag",    {28'd0, finished_alu_rob_entry}, {28'd0, q[0].tag});
            check("result", alu_result, q[0].res);
            check("npc",    next_pc,    q[0].npc);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        check_outputs();
    endtask

    task automatic dispatch(input logic [6:0] opc, input logic [2:0] f3, input logic add,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic [RB-1:0] tag);
        start_alu     = 1'b1;
        op_type       = opc;
        op            = f3;
        op_addition   = add;
        vi            = a;
        vj            = b;
        pc_in         = pc;
        imm_in        = imm;
        alu_rob_entry = tag;
    endtask

    logic [6:0] opc_tbl [9];

    initial begin
        opc_tbl = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h03, 7'h33};
        rst_in = 1'b1; rdy_in = 1'b0; rob_clear_up = 1'b0; start_alu = 1'b0;
        cdb_grant = 1'b0;
        dispatch(7'h33, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        start_alu = 1'b0;

        // Reset with rdy_in low still clears.
        tick();
        check("rst_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_full",  {31'd0, alu_full},  32'd0);
        check("rst_tag",   {28'd0, finished_alu_rob_entry}, 32'd0);
        check("rst_res",   alu_result, 32'd0);
        check("rst_npc",   next_pc,    32'd0);
        rst_in = 1'b0; rdy_in = 1'b1;

        // sub: 5 - 7
        dispatch(7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 32'h40, 32'd0, 4'd3);
        tick();
        check("sub_ready", {31'd0, alu_ready}, 32'd1);
        check("sub_res",   alu_result, 32'hFFFF_FFFE);
        check("sub_tag",   {28'd0, finished_alu_rob_entry}, 32'd3);
        check("sub_npc",   next_pc, 32'h44);
        start_alu = 1'b0; cdb_grant = 1'b1;
        tick();

        // bne taken, then beq not taken pushed while the bne result pops.
        cdb_grant = 1'b0;
        dispatch(7'h63, 3'd1, 1'b0, 32'd1, 32'd2, 32'h100, 32'h20, 4'd4);
        tick();
        check("bne_res", alu_result, 32'd1);
        check("bne_npc", next_pc, 32'h120);
        cdb_grant = 1'b1;
        dispatch(7'h63, 3'd0, 1'b0, 32'd1, 32'd2, 32'h100, 32'h20, 4'd5);
        tick();
        check("beq_res", alu_result, 32'd0);
        check("beq_npc", next_pc, 32'h104);
        check("beq_tag", {28'd0, finished_alu_rob_entry}, 32'd5);
        start_alu = 1'b0;
        tick();

        // jalr, then addi with inst[30] set (must still add).
        cdb_grant = 1'b0;
        dispatch(7'h67, 3'd0, 1'b0, 32'h1003, 32'd0, 32'h200, 32'd4, 4'd6);
        tick();
        check("jalr_res", alu_result, 32'h204);
        check("jalr_npc", next_pc, 32'h1006);
        cdb_grant = 1'b1;
        dispatch(7'h13, 3'd0, 1'b1, 32'd1, 32'd1, 32'h300, 32'd1, 4'd7);
        tick();
        check("addi_res", alu_result, 32'd2);
        start_alu = 1'b0;
        tick();

        // Fill the buffer; third dispatch is dropped.
        cdb_grant = 1'b0;
        dispatch(7'h33, 3'd4, 1'b0, 32'hF0, 32'h0F, 32'h10, 32'd0, 4'd1);
        tick();
        dispatch(7'h33, 3'd6, 1'b0, 32'hF0, 32'h0F, 32'h14, 32'd0, 4'd2);
        tick();
        check("full_after2", {31'd0, alu_full}, 32'd1);
        dispatch(7'h33, 3'd7, 1'b0, 32'hF0, 32'h0F, 32'h18, 32'd0, 4'd3);
        tick();
        check("full_head", {28'd0, finished_alu_rob_entry}, 32'd1);
        start_alu = 1'b0; cdb_grant = 1'b1;
        tick();
        check("drain_tag2", {28'd0, finished_alu_rob_entry}, 32'd2);
        tick();
        check("drain_empty", {31'd0, alu_ready}, 32'd0);

        // Push+pop at count 1, then flush with a dispatch.
        cdb_grant = 1'b0;
        dispatch(7'h37, 3'd0, 1'b0, 32'd0, 32'd0, 32'h20, 32'hABCD_E000, 4'd8);
        tick();
        cdb_grant = 1'b1;
        dispatch(7'h17, 3'd0, 1'b0, 32'd0, 32'd0, 32'h20, 32'h1000, 4'd9);
        tick();
        check("pp_full", {31'd0, alu_full}, 32'd0);
        check("pp_tag",  {28'd0, finished_alu_rob_entry}, 32'd9);
        rob_clear_up = 1'b1;
        dispatch(7'h6F, 3'd0, 1'b0, 32'd0, 32'd0, 32'h30, 32'h40, 4'd10);
        tick();
        check("flush_ready", {31'd0, alu_ready}, 32'd0);
        rob_clear_up = 1'b0; start_alu = 1'b0;
        tick();
        check("flush_stays", {31'd0, alu_ready}, 32'd0);

        // rdy_in low holds the head even with grant and dispatch asserted.
        cdb_grant = 1'b0;
        dispatch(7'h33, 3'd1, 1'b0, 32'h1, 32'd4, 32'h50, 32'd0, 4'd11);
        tick();
        rdy_in = 1'b0; cdb_grant = 1'b1;
        dispatch(7'h33, 3'd0, 1'b0, 32'd9, 32'd9, 32'h60, 32'd0, 4'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_tag", {28'd0, finished_alu_rob_entry}, 32'd11);
            check("hold_res", alu_result, 32'h10);
        end
        rdy_in = 1'b1; cdb_grant = 1'b0;
        dispatch(7'h33, 3'd0, 1'b0, 32'd9, 32'd9, 32'h60, 32'd0, 4'd13);
        tick();
        start_alu = 1'b0; rst_in = 1'b1;
        tick();
        check("mrst_ready", {31'd0, alu_ready}, 32'd0);
        check("mrst_full",  {31'd0, alu_full},  32'd0);
        check("mrst_tag",   {28'd0, finished_alu_rob_entry}, 32'd0);
        check("mrst_res",   alu_result, 32'd0);
        check("mrst_npc",   next_pc,    32'd0);
        rst_in = 1'b0;

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            rst_in       = ($urandom_range(0, 199) == 0);
            rdy_in       = ($urandom_range(0, 7) != 0);
            rob_clear_up = ($urandom_range(0, 19) == 0);
            cdb_grant    = $urandom_range(0, 1) == 1;
            start_alu    = ($urandom_range(0, 3) != 0);
            op_type      = opc_tbl[$urandom_range(0, 8)];
            op           = 3'($urandom);
            op_addition  = 1'($urandom);
            vi           = $urandom;
            vj           = ($urandom_range(0, 3) == 0) ? vi : $urandom;
            if ($urandom_range(0, 3) == 0) vj = {27'd0, 5'($urandom)};
            pc_in        = $urandom & 32'hFFFF_FFFC;
            imm_in       = $urandom;
            alu_rob_entry = RB'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter ROB_BIT, default from shared constant, meaning ROB tag width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning result buffer entries (power of two).
REQ-003 clk_in  in  1  system clock; one clock domain only.
REQ-004 rst_in  in  1  reset, synchronous, active-high.
REQ-005 rdy_in  in  1  global ready; low = hold all state.
REQ-006 rob_clear_up  in  1  mispredict flush from ROB.
REQ-007 start_alu  in  1  RS dispatch valid.
REQ-008 vi, vj  in  32 each  operand 1 and operand 2 (vj already immediate for OP-IMM).
REQ-009 op  in  3  funct3; op_type  in  7  opcode; op_addition  in  1  inst[30].
REQ-010 alu_rob_entry  in  ROB_BIT  destination ROB tag.
REQ-011 pc_in  in  32  instruction address; imm_in  in  32  sign-extended immediate.
REQ-012 cdb_grant  in  1  CDB arbiter accepts head result this cycle.
REQ-013 alu_full  out  1  buffer full; RS SHALL NOT dispatch while high.
REQ-014 alu_ready  out  1  head result valid; finished_alu_rob_entry  out  ROB_BIT; alu_result  out  32; next_pc  out  32.

Function
REQ-015 Dispatch accepted iff rdy_in && start_alu && !alu_full && !rob_clear_up; accepted op computed and pushed in same edge.
REQ-016 Latency: result visible on alu_ready/outputs the cycle after acceptance at earliest (registered outputs, no combinational input-to-output path).
REQ-017 OP (0110011): add/sub (op_addition=1 -> sub), sll, slt, sltu, xor, srl/sra (op_addition), or, and; shift amount vj[4:0].
REQ-018 OP-IMM (0010011): same set; op_addition ignored except funct3=101 (srli/srai); addi never subtracts.
REQ-019 BRANCH (1100011): beq/bne/blt/bge/bltu/bgeu on vi,vj; alu_result = 1 taken else 0; next_pc = taken ? pc_in+imm_in : pc_in+4.
REQ-020 JAL: alu_result = pc_in+4, next_pc = pc_in+imm_in; JALR: alu_result = pc_in+4, next_pc = (vi+imm_in) & ~1.
REQ-021 LUI: alu_result = imm_in; AUIPC: alu_result = pc_in+imm_in; all non-control ops next_pc = pc_in+4.
REQ-022 Unknown opcode: alu_result = 0, next_pc = pc_in+4, entry still pushed.
REQ-023 All arithmetic modulo 2^32; signed compares two's complement.
REQ-024 Buffer is in-order FIFO; head popped on rdy_in && alu_ready && cdb_grant.
REQ-025 alu_ready = (count != 0); outputs hold head value stably until popped.
REQ-026 Simultaneous push and pop: count unchanged, both take effect; when full, push blocked even if pop occurs (alu_full reflects registered count).
REQ-027 Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-028 start_alu while alu_full: ignored, no state change.
REQ-029 rob_clear_up (with rdy_in high): count, pointers cleared next edge; same-cycle dispatch and pop discarded; alu_ready low next cycle.
REQ-030 rdy_in low: no push, no pop, no flush; all registers hold.

Reset
REQ-031 On rst_in, regardless of rdy_in: count=0, pointers=0, alu_ready=0, alu_full=0, finished_alu_rob_entry=0, alu_result=0, next_pc=0.
REQ-032 Reset mid-operation discards all buffered results; first dispatch after reset behaves as from empty.

Structure
REQ-033 Opcode constants, ROB_BIT and FIFO_DEPTH default SHALL live in shared Const.v.
REQ-034 Computation SHALL be combinational sub-module alu_core (operands, op, op_type, op_addition, pc, imm -> result, next_pc); alu_unit owns FIFO, handshake, flush.

Verification
REQ-035 add: vi=5, vj=7, op=000, OP, op_addition=1, tag=3 -> next cycle alu_ready=1, result=0xFFFFFFFE, tag 3, next_pc=pc+4.
REQ-036 bne vi=1, vj=2, pc=0x100, imm=0x20 -> result=1, next_pc=0x120; beq same operands -> result=0, next_pc=0x104.
REQ-037 jalr vi=0x1003, imm=4, pc=0x200 -> result=0x204, next_pc=0x1006; addi op_addition=1 vi=1 vj=1 -> result=2.
REQ-038 cdb_grant=0, dispatch 3 ops -> alu_full=1 after 2, third ignored; then grant each cycle -> tags emerge in order, first two only.
REQ-039 count=1, dispatch and grant same cycle -> count stays 1, new result at head next cycle; then rob_clear_up with dispatch -> alu_ready=0 next cycle, nothing emitted.
REQ-040 rdy_in=0 for 3 cycles with buffered head and grant high -> outputs unchanged; rst_in mid-stream -> all outputs 0 next cycle.
